// File: rtl/wallace_multiplier_pkg.sv
// Shared constants and helpers for the Wallace-tree multiplier.
// Includes constant functions that size the reduction tree at elaboration time.
package wallace_multiplier_pkg;

    localparam int WIDTH_DEFAULT      = 128;
    localparam int PROD_WIDTH_DEFAULT = 2 * WIDTH_DEFAULT;

    // Each group of three rows becomes two; up to two leftover rows pass straight through.
    function automatic int next_rows(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int num_layers(input int n);
        int rows;
        int layers;
        rows   = n;
        layers = 0;
        while (rows > 2) begin
            rows   = next_rows(rows);
            layers = layers + 1;
        end
        return layers;
    endfunction

    function automatic int rows_at(input int n, input int layer);
        int rows;
        rows = n;
        for (int k = 0; k < layer; k++) begin
            rows = next_rows(rows);
        end
        return rows;
    endfunction

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (c & (x ^ y));
    endfunction

endpackage

// File: rtl/wallace_multiplier_ripple_carry_adder.sv
// Final carry-propagate adder: a chain of adder cells, half adder at bit 0.
// The carry out of the top bit is dropped; the product never needs it.
module ripple_carry_adder
    import wallace_multiplier_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] sum_o
);

    // Carry ripples LSB to MSB; a zero carry-in turns bit 0 into a half adder.
    always_comb begin
        logic carry_v;
        sum_o   = {WIDTH{1'b0}};
        carry_v = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = fa_sum(x_i[i], y_i[i], carry_v);
            carry_v  = fa_carry(x_i[i], y_i[i], carry_v);
        end
    end

endmodule

// File: rtl/wallace_multiplier.sv
// Unsigned WIDTH x WIDTH multiplier: AND-array partial products, Wallace carry-save
// reduction to two rows, ripple-carry final add, one output register.
module wallace_multiplier
    import wallace_multiplier_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result
);

    localparam int PW     = 2 * WIDTH;
    localparam int LAYERS = num_layers(WIDTH);

    logic [PW-1:0] sum_s;
    logic [PW-1:0] result_d;
    logic [PW-1:0] result_q;

    function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                              input logic [PW-1:0] z);
        return x ^ y ^ z;
    endfunction

    function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                                input logic [PW-1:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // Layer 0 holds the partial products; every later layer is one 3:2 reduction step.
    for (genvar l = 0; l <= LAYERS; l++) begin : gen_layer
        localparam int ROWS = rows_at(WIDTH, l);
        logic [PW-1:0] row_s [ROWS];

        if (l == 0) begin : g_pp
            for (genvar i = 0; i < WIDTH; i++) begin : g_row
                assign row_s[i] = {{WIDTH{1'b0}}, a & {WIDTH{b[i]}}} << i;
            end
        end else begin : g_csa
            localparam int PREV   = rows_at(WIDTH, l - 1);
            localparam int GROUPS = PREV / 3;
            for (genvar g = 0; g < GROUPS; g++) begin : g_fa
                assign row_s[2*g]   = csa_sum(gen_layer[l-1].row_s[3*g],
                                              gen_layer[l-1].row_s[3*g+1],
                                              gen_layer[l-1].row_s[3*g+2]);
                assign row_s[2*g+1] = csa_carry(gen_layer[l-1].row_s[3*g],
                                                gen_layer[l-1].row_s[3*g+1],
                                                gen_layer[l-1].row_s[3*g+2]);
            end
            for (genvar r = 0; r < PREV % 3; r++) begin : g_pass
                assign row_s[2*GROUPS+r] = gen_layer[l-1].row_s[3*GROUPS+r];
            end
        end
    end

    ripple_carry_adder #(
        .WIDTH (PW)
    ) u_final_adder (
        .x_i   (gen_layer[LAYERS].row_s[0]),
        .y_i   (gen_layer[LAYERS].row_s[1]),
        .sum_o (sum_s)
    );

    // Next product value straight from the combinational tree.
    always_comb begin
        result_d = sum_s;
    end

    // Result register; reset clears it immediately and drops any in-flight product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= {PW{1'b0}};
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_wallace_multiplier.sv
// Directed self-checking bench for wallace_multiplier at WIDTH=128.
module tb_wallace_multiplier;

    logic         clk;
    logic         rst;
    logic [127:0] a;
    logic [127:0] b;
    logic [255:0] result;

    int checks;
    int errors;

    wallace_multiplier #(
        .WIDTH (128)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_and_check(input string tag, input logic [127:0] av,
                                   input logic [127:0] bv, input logic [255:0] exp);
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        check(tag, result, exp);
    endtask

    initial begin
        logic [127:0] max_v;
        logic [255:0] exp_v;
        checks = 0;
        errors = 0;
        max_v  = {128{1'b1}};
        rst    = 1'b0;
        a      = 128'd5315;
        b      = 128'd8209;
        #1 rst = 1'b1;

        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_hold", result, 256'd0);
        end

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("released_before_edge", result, 256'd0);
        @(posedge clk);
        #1;
        check("first_product", result, 256'd43630835);

        exp_v = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h0000_0000_0000_0000_0000_0000_0000_0001};
        drive_and_check("max_times_max", max_v, max_v, exp_v);
        drive_and_check("zero_times_max", 128'd0, max_v, 256'd0);
        drive_and_check("one_times_2p127", 128'd1, 128'd1 << 127, 256'd1 << 127);
        drive_and_check("max_times_one", max_v, 128'd1, {128'd0, max_v});
        drive_and_check("max_times_zero", max_v, 128'd0, 256'd0);
        drive_and_check("three_times_seven", 128'd3, 128'd7, 256'd21);
        drive_and_check("2p64_squared", 128'd1 << 64, 128'd1 << 64, 256'd1 << 128);
        drive_and_check("2p127_squared", 128'd1 << 127, 128'd1 << 127, 256'd1 << 254);
        drive_and_check("u32max_squared", 128'hFFFF_FFFF, 128'hFFFF_FFFF, 256'hFFFF_FFFE_0000_0001);
        drive_and_check("decimal_pair", 128'd12345678, 128'd87654321, 256'd1082152022374638);

        drive_and_check("pre_reset_21", 128'd3, 128'd7, 256'd21);
        #2 rst = 1'b1;
        #1;
        check("async_reset_clears", result, 256'd0);
        a = 128'd1000;
        b = 128'd1000;
        @(posedge clk);
        #1;
        check("reset_over_edge", result, 256'd0);
        rst = 1'b0;
        #1;
        check("no_stale_after_release", result, 256'd0);
        @(posedge clk);
        #1;
        check("after_release", result, 256'd1000000);

        a = 128'd11;
        b = 128'd13;
        @(posedge clk);
        #1;
        a = 128'd100;
        b = 128'd100;
        #3;
        check("late_change_ignored", result, 256'd143);
        @(posedge clk);
        #1;
        check("late_change_applied", result, 256'd10000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wallace_multiplier.md
WALLACE_MULTIPLIER -- requirements
Module: wallace_multiplier

Interface
REQ-001 Parameter WIDTH, default 128: operand width in bits; result width is 2*WIDTH.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a  input  WIDTH  unsigned multiplicand.
REQ-005 b  input  WIDTH  unsigned multiplier.
REQ-006 result  output  2*WIDTH  unsigned product, registered.
REQ-007 The block SHALL have one clock (clk) and an asynchronous, active-high reset (rst); no other control or handshake ports.

Function
REQ-008 The block SHALL compute the full unsigned product a*b with no truncation, overflow or saturation.
- 2*WIDTH bits always suffice: max (2^WIDTH-1)^2.
REQ-009 Latency SHALL be exactly 1 cycle: result after rising edge N equals a*b sampled at edge N.
REQ-010 Throughput SHALL be one product per cycle; new operands accepted every cycle, no stall or valid signal.
REQ-011 Partial products SHALL be generated as WIDTH rows of a AND b[i], each row shifted left by i.
REQ-012 Partial-product rows SHALL be reduced by Wallace-tree layers of 3:2 carry-save compressors (full adders) and 2:2 half adders until exactly two rows remain.
REQ-013 The final two rows SHALL be summed by a 2*WIDTH-bit ripple-carry adder; its carry-out SHALL be discarded (always 0 for a valid product).
REQ-014 The tree and the final adder SHALL be purely combinational between the operand inputs and the result register; no internal pipeline registers.
REQ-015 Operand 0 on either input SHALL yield result 0; operand 1 SHALL yield the other operand zero-extended.
REQ-016 If operands change between edges, only the values present at the rising edge SHALL affect result.

Reset
REQ-017 While rst is high, result SHALL be 0, asynchronously and immediately, independent of clk.
REQ-018 On the first rising edge after rst deasserts, result SHALL load a*b of the current operands.
REQ-019 If rst asserts mid-stream, the in-flight product SHALL be discarded; no stale value is output after release.

Structure
REQ-020 A shared package SHALL hold the WIDTH default (128) and the derived product width constant (2*WIDTH).
REQ-021 The block SHALL contain one sub-module, ripple_carry_adder (parameterised width, chained full-adder cells), for the final addition.
REQ-022 Reduction layers SHALL be generated with generate loops so any WIDTH >= 2 elaborates; RTL stays within 120-400 lines.

Verification
REQ-023 rst=1, a=5315, b=8209, clock running -> result=0 throughout reset.
REQ-024 rst=0, a=5315, b=8209 -> after one rising edge result=43630835.
REQ-025 a=2^128-1, b=2^128-1 -> result=2^256-2^129+1 (all carries propagate).
REQ-026 a=0, b=2^128-1; then a=1, b=2^127 -> result 0, then 2^127.
REQ-027 Back-to-back a=3,b=7 then a=2^64,b=2^64 on consecutive edges -> result 21, then 2^128, one cycle each.
REQ-028 Assert rst between clock edges while result=21 -> result falls to 0 before the next edge.
